// File: rtl/cpu_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, error codes, FSM states, request checker.
package cpu_lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Classify a request before it reaches the bus; illegal funct3 takes priority over alignment.
  function automatic lsu_err_e check_req(input logic we, input logic [2:0] f3,
                                         input logic [1:0] alo, input logic chk_align);
    logic illegal;
    logic mis;
    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && we);
    case (f3)
      SZ_H, SZ_HU: mis = alo[0];
      SZ_W:        mis = |alo;
      default:     mis = 1'b0;
    endcase
    if (illegal)              return ERR_ILLEGAL;
    else if (chk_align && mis) return ERR_MISALIGN;
    else                      return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Bus transaction watchdog: counts cycles spent in REQ/WAIT, flags the last permitted cycle.
module lsu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // Count holds at the limit; the first REQ cycle sees zero, so expiry marks cycle TIMEOUT_CYCLES.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)       cnt <= '0;
    else if (i_en && !o_expired) cnt <= cnt + 1'b1;
  end

  assign o_expired = (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one request at a time, single Wishbone-style transaction, ack or timeout response.
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_err,
  output logic        o_busy,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);
  lsu_state_e state_q, state_d;
  lsu_req_t   req_q;
  lsu_err_e   err_q, chk_err;
  logic [31:0] rdata_q;
  logic       in_bus, expired, accept, take_ack, time_out;

  assign in_bus   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign accept   = (state_q == ST_IDLE) && i_req_valid;
  assign chk_err  = check_req(i_req_we, i_req_funct3, i_req_addr[1:0], CHECK_ALIGN);
  // An ack only counts once the strobe has been taken (REQ without stall) or while waiting.
  assign take_ack = ((state_q == ST_REQ) && !i_wb_stall && i_wb_ack) ||
                    ((state_q == ST_WAIT) && i_wb_ack);
  assign time_out = in_bus && expired && !take_ack;

  lsu_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (!in_bus),
    .i_en      (in_bus),
    .o_expired (expired)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: ack beats timeout; a strobe accepted without ack moves to WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) state_d = (chk_err == ERR_OK) ? ST_REQ : ST_RESP;
      ST_REQ: begin
        if (take_ack || expired) state_d = ST_RESP;
        else if (!i_wb_stall)    state_d = ST_WAIT;
      end
      ST_WAIT: if (take_ack || expired) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and response data/error registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q   <= '{we: i_req_we, funct3: i_req_funct3, addr: i_req_addr, wdata: i_req_wdata};
        err_q   <= chk_err;
        rdata_q <= '0;
      end
      if (take_ack) begin
        err_q   <= ERR_OK;
        rdata_q <= req_q.we ? 32'h0 : i_wb_data;
      end else if (time_out) begin
        err_q   <= ERR_TIMEOUT;
        rdata_q <= '0;
      end
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_rdata = o_rsp_valid ? rdata_q : 32'h0;
  assign o_rsp_err   = o_rsp_valid ? err_q : ERR_OK;
  assign o_wb_stb    = (state_q == ST_REQ);
  assign o_wb_we     = req_q.we;
  assign o_wb_addr   = req_q.addr;
  assign o_wb_data   = req_q.wdata;
  assign o_wb_sel    = req_q.funct3;
endmodule
